compare_bank: RTL

COMPARE_BANK -- requirements
Module: compare_bank

---
 rtl/compare_bank.sv | 114 +++++++++++
 1 files changed

// File: rtl/compare_bank.sv
// Bank of independent comparators checking a live value against per-channel operands; arm/fire/disarm control per channel.
// Outputs are registered with 1-cycle latency. There is no backpressure: every in-range write is accepted on the edge it is presented.
module compare_bank #(
    parameter  int WIDTH    = 24,
    parameter  int CHANNELS = 4,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [WIDTH-1:0]    dataa,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_value,
    input  logic [1:0]          wr_mode,
    input  logic                wr_oneshot,
    input  logic [CHANNELS-1:0] disarm,
    input  logic [CHANNELS-1:0] flag_clr,
    output logic [CHANNELS-1:0] armed,
    output logic [CHANNELS-1:0] match,
    output logic [CHANNELS-1:0] event_o,
    output logic [CHANNELS-1:0] flag
);

    typedef enum logic [1:0] {
        MODE_EQ = 2'b00,
        MODE_GE = 2'b01,
        MODE_LE = 2'b10,
        MODE_NE = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        FIRED = 2'b10
    } state_t;

    localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CHANNELS);

    logic wr_in_range;

    // With a non-power-of-two channel count, indices past the last channel are dropped.
    assign wr_in_range = ({1'b0, wr_ch} < CH_LIMIT);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] datab_q;
        mode_t            mode_q;
        logic             oneshot_q;
        state_t           state_q;
        logic             match_q;
        logic             event_q;
        logic             flag_q;
        logic             cond;
        logic             wr_hit;
        logic             fire;

        always_comb begin
            cond = 1'b0;
            case (mode_q)
                MODE_EQ: cond = (dataa == datab_q);
                MODE_GE: cond = (dataa >= datab_q);
                MODE_LE: cond = (dataa <= datab_q);
                MODE_NE: cond = (dataa != datab_q);
                default: cond = 1'b0;
            endcase
        end

        assign wr_hit = wr_en && wr_in_range && (wr_ch == CH_W'(i));

        // A rewrite takes over the channel, so the old setup cannot fire on the load edge.
        assign fire = (state_q == ARMED) && cond && !match_q && !disarm[i] && !wr_hit;

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                datab_q   <= '0;
                mode_q    <= MODE_EQ;
                oneshot_q <= 1'b0;
                state_q   <= IDLE;
                match_q   <= 1'b0;
                event_q   <= 1'b0;
                flag_q    <= 1'b0;
            end else begin
                if (wr_hit) begin
                    datab_q   <= wr_value;
                    mode_q    <= mode_t'(wr_mode);
                    oneshot_q <= wr_oneshot;
                end

                // Clearing match on load lets an already-true condition look like a fresh rising edge.
                match_q <= wr_hit ? 1'b0 : cond;
                event_q <= fire;

                if (disarm[i]) begin
                    state_q <= IDLE;
                end else if (wr_hit) begin
                    state_q <= ARMED;
                end else if (fire && oneshot_q) begin
                    state_q <= FIRED;
                end

                if (fire) begin
                    flag_q <= 1'b1;
                end else if (flag_clr[i]) begin
                    flag_q <= 1'b0;
                end
            end
        end

        assign armed[i]   = (state_q == ARMED);
        assign match[i]   = match_q;
        assign event_o[i] = event_q;
        assign flag[i]    = flag_q;
    end

endmodule
